// File: rtl/key_event_queue_pkg.sv
// keyev_pkg: event types, FSM states and the queued event record for key_event_queue.
package keyev_pkg;
    typedef enum logic [1:0] {
        EV_CHAR  = 2'd0,
        EV_ENTER = 2'd1,
        EV_BKSP  = 2'd2
    } ev_type_t;
    typedef enum logic {
        S_MAKE,
        S_BREAK
    } keyev_state_t;
    typedef struct packed {
        ev_type_t   ev_type;
        logic [7:0] code;
    } key_event_t;
    localparam int EV_W = $bits(key_event_t);
endpackage

// File: rtl/key_event_queue_fifo.sv
// event_fifo: first-word-fall-through FIFO; head reads as zero while empty.
module event_fifo #(
    parameter int DEPTH = 8,
    parameter int W = 10
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0] wptr, rptr;
    logic [W-1:0] mem [DEPTH];
    logic rd, wr;
    assign empty = wptr == rptr;
    assign full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rd = pop && !empty;
    assign wr = push && (!full || rd);
    assign dout = empty ? '0 : mem[rptr[AW-1:0]];
    always_ff @(posedge clk_in) begin
        if (wr)
            mem[wptr[AW-1:0]] <= din;
    end
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr)
                wptr <= wptr + 1'b1;
            if (rd)
                rptr <= rptr + 1'b1;
        end
    end
endmodule

// File: rtl/key_event_queue.sv
// key_event_queue: make/break tracker emitting one event per key release into a valid/ready FIFO.
module key_event_queue
    import keyev_pkg::*;
#(
    parameter int          DEPTH = 8,
    parameter logic [15:0] BREAK_TIMEOUT = 16'd50000
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [7:0] scancode_in,
    input  logic       key_in,
    input  logic       enter_in,
    input  logic       bksp_in,
    input  logic       break_in,
    output logic       ev_valid_out,
    input  logic       ev_ready_in,
    output logic [1:0] ev_type_out,
    output logic [7:0] ev_code_out,
    output logic [7:0] drop_count_out,
    output logic [7:0] timeout_count_out
);
    keyev_state_t state;
    logic [15:0] tmr;
    logic code_hit, push, full, empty;
    ev_type_t in_type;
    key_event_t din, head;
    assign code_hit = key_in || enter_in || bksp_in;
    assign in_type = enter_in ? EV_ENTER : bksp_in ? EV_BKSP : EV_CHAR;
    assign push = state == S_BREAK && !break_in && code_hit;
    assign din = '{ev_type: in_type, code: scancode_in};
    assign ev_valid_out = !empty;
    assign ev_type_out = head.ev_type;
    assign ev_code_out = head.code;
    event_fifo #(.DEPTH(DEPTH), .W(EV_W)) u_fifo (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .push   (push),
        .pop    (ev_ready_in),
        .din    (din),
        .dout   (head),
        .full   (full),
        .empty  (empty)
    );
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= S_MAKE;
            tmr <= '0;
            drop_count_out <= '0;
            timeout_count_out <= '0;
        end else begin
            if (break_in) begin
                state <= S_BREAK;
                tmr <= '0;
            end else if (state == S_BREAK) begin
                if (code_hit)
                    state <= S_MAKE;
                else if (tmr == BREAK_TIMEOUT - 16'd1) begin
                    state <= S_MAKE;
                    if (timeout_count_out != 8'hff)
                        timeout_count_out <= timeout_count_out + 8'd1;
                end else
                    tmr <= tmr + 16'd1;
            end
            // a full FIFO is never empty, so the pop is exactly ev_ready_in
            if (push && full && !ev_ready_in && drop_count_out != 8'hff)
                drop_count_out <= drop_count_out + 8'd1;
        end
    end
endmodule
